// File: rtl/sd_frame_pkg.sv
`default_nettype none
// ============================================================================
// sd_frame_pkg : state encoding, mode constants and defaults for the shifter
// Rev 1.0
// ============================================================================
package sd_frame_pkg;

  localparam int DEF_MAX_FRAME = 48;
  localparam int DEF_FSIZE_W   = 6;
  localparam int DEF_TIMEOUT   = 64;

  localparam logic MODE_TX     = 1'b0;
  localparam logic MODE_RX     = 1'b1;
  localparam logic SERIAL_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX_SHIFT = 3'd1,
    ST_RX_WAIT  = 3'd2,
    ST_RX_SHIFT = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  function automatic logic frame_len_ok(input int n, input int max_frame);
    return (n != 0) && (n <= max_frame);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_bit_counter.sv
`default_nettype none
// ============================================================================
// sd_bit_counter : loadable down-counter with enable and terminal-count flag
// Rev 1.0
// ============================================================================
module sd_bit_counter
  import sd_frame_pkg::*;
#(
  parameter int WIDTH = DEF_FSIZE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  // Saturates at zero so a stray decrement cannot wrap to all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      if (i_load) begin
        r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
        r_count <= r_count - WIDTH'(1);
      end
    end
  end

  assign o_tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sd_frame_shifter.sv
`default_nettype none
// ============================================================================
// sd_frame_shifter : bidirectional MSB-first frame shifter for the SD CMD/DAT
// line, with receive start-bit timeout. Rev 1.0
// ============================================================================
module sd_frame_shifter
  import sd_frame_pkg::*;
#(
  parameter int MAX_FRAME = DEF_MAX_FRAME,
  parameter int FSIZE_W   = DEF_FSIZE_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 iSD_clock,
  input  logic                 iReset,
  input  logic                 iEnable,
  input  logic                 iMode,
  input  logic [FSIZE_W-1:0]   iFramesize,
  input  logic                 iLoad_send,
  input  logic [MAX_FRAME-1:0] iParallel,
  input  logic                 iSerial,
  output logic                 oSerial,
  output logic                 oOutput_input,
  output logic [MAX_FRAME-1:0] oParallel,
  output logic                 oBusy,
  output logic                 oComplete,
  output logic                 oTimeout
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t               r_state;
  logic [MAX_FRAME-1:0] r_shift;
  logic [MAX_FRAME-1:0] r_parallel;
  logic                 r_serial;
  logic                 r_oe;
  logic                 r_complete;
  logic                 r_timeout;

  logic                 w_start;
  logic                 w_bit_dec;
  logic                 w_to_dec;
  logic                 w_bit_tc;
  logic                 w_to_tc;
  logic [MAX_FRAME-1:0] w_tx_aligned;
  logic [MAX_FRAME-1:0] w_rx_next;

  assign w_start = iLoad_send && (r_state == ST_IDLE) &&
                   frame_len_ok(int'(iFramesize), MAX_FRAME);

  // Left-align the frame so bit N-1 sits at the MSB and shifts out first.
  assign w_tx_aligned = iParallel << (MAX_FRAME - int'(iFramesize));
  assign w_rx_next    = {r_shift[MAX_FRAME-2:0], iSerial};

  always_comb begin
    w_bit_dec = 1'b0;
    w_to_dec  = 1'b0;
    case (r_state)
      ST_TX_SHIFT, ST_RX_SHIFT: w_bit_dec = !w_bit_tc;
      ST_RX_WAIT: begin
        w_bit_dec = !iSerial && !w_bit_tc;
        w_to_dec  = iSerial && !w_to_tc;
      end
      default: ;
    endcase
  end

  sd_bit_counter #(.WIDTH(FSIZE_W)) u_bit_cnt (
    .clk        (iSD_clock),
    .rst        (iReset),
    .i_en       (iEnable),
    .i_load     (w_start),
    .i_load_val (iFramesize - FSIZE_W'(1)),
    .i_dec      (w_bit_dec),
    .o_tc       (w_bit_tc)
  );

  sd_bit_counter #(.WIDTH(TO_W)) u_to_cnt (
    .clk        (iSD_clock),
    .rst        (iReset),
    .i_en       (iEnable),
    .i_load     (w_start),
    .i_load_val (TO_W'(TIMEOUT - 1)),
    .i_dec      (w_to_dec),
    .o_tc       (w_to_tc)
  );

  always_ff @(posedge iSD_clock or posedge iReset) begin
    if (iReset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_parallel <= '0;
      r_serial   <= SERIAL_IDLE;
      r_oe       <= 1'b0;
      r_complete <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (iEnable) begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            if (iMode == MODE_TX) begin
              r_state  <= ST_TX_SHIFT;
              r_oe     <= 1'b1;
              r_serial <= w_tx_aligned[MAX_FRAME-1];
              r_shift  <= w_tx_aligned << 1;
            end else begin
              r_state <= ST_RX_WAIT;
              r_shift <= '0;
            end
          end
        end
        ST_TX_SHIFT: begin
          if (w_bit_tc) begin
            r_state    <= ST_DONE;
            r_serial   <= SERIAL_IDLE;
            r_oe       <= 1'b0;
            r_complete <= 1'b1;
          end else begin
            r_serial <= r_shift[MAX_FRAME-1];
            r_shift  <= r_shift << 1;
          end
        end
        ST_RX_WAIT: begin
          // A start bit on the final wait cycle still wins over the timeout.
          if (!iSerial) begin
            r_shift <= w_rx_next;
            if (w_bit_tc) begin
              r_state    <= ST_DONE;
              r_parallel <= w_rx_next;
              r_complete <= 1'b1;
            end else begin
              r_state <= ST_RX_SHIFT;
            end
          end else if (w_to_tc) begin
            r_state    <= ST_DONE;
            r_complete <= 1'b1;
            r_timeout  <= 1'b1;
          end
        end
        ST_RX_SHIFT: begin
          r_shift <= w_rx_next;
          if (w_bit_tc) begin
            r_state    <= ST_DONE;
            r_parallel <= w_rx_next;
            r_complete <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_complete <= 1'b0;
          r_timeout  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oSerial       = r_serial;
  assign oOutput_input = r_oe;
  assign oParallel     = r_parallel;
  assign oBusy         = (r_state != ST_IDLE);
  assign oComplete     = r_complete;
  assign oTimeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sd_frame_shifter.sv
`default_nettype none
// ============================================================================
// tb_sd_frame_shifter : directed vector table plus hand-written corner cases
// Rev 1.0
// ============================================================================
module tb_sd_frame_shifter;
  import sd_frame_pkg::*;

  logic        clk = 1'b0;
  logic        iReset;
  logic        iEnable;
  logic        iMode;
  logic [5:0]  iFramesize;
  logic        iLoad_send;
  logic [47:0] iParallel;
  logic        iSerial;
  logic        oSerial;
  logic        oOutput_input;
  logic [47:0] oParallel;
  logic        oBusy;
  logic        oComplete;
  logic        oTimeout;

  int n_pass  = 0;
  int n_total = 0;

  sd_frame_shifter #(.MAX_FRAME(48), .FSIZE_W(6), .TIMEOUT(64)) dut (
    .iSD_clock     (clk),
    .iReset        (iReset),
    .iEnable       (iEnable),
    .iMode         (iMode),
    .iFramesize    (iFramesize),
    .iLoad_send    (iLoad_send),
    .iParallel     (iParallel),
    .iSerial       (iSerial),
    .oSerial       (oSerial),
    .oOutput_input (oOutput_input),
    .oParallel     (oParallel),
    .oBusy         (oBusy),
    .oComplete     (oComplete),
    .oTimeout      (oTimeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        mode;
    logic [5:0]  n;
    logic [47:0] par_in;   // TX frame, or RX frame driven on iSerial
    int          pre;      // idle ones before the RX start bit
    logic [47:0] exp;      // TX: expected line bits; RX: expected oParallel
    logic        exp_to;
    logic        valid;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  task automatic load(input logic mode, input logic [5:0] n, input logic [47:0] par);
    iMode      = mode;
    iFramesize = n;
    iParallel  = par;
    iLoad_send = 1'b1;
    tick();
    iLoad_send = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int nn;
    nn = int'(v.n);
    load(v.mode, v.n, v.par_in);
    if (!v.valid) begin
      check({v.name, "_busy"}, oBusy, 0);
      for (int k = 0; k < 3; k++) begin
        tick();
        check({v.name, "_nocomplete"}, oComplete, 0);
      end
    end else if (v.mode == MODE_TX) begin
      for (int k = 0; k < nn; k++) begin
        check({v.name, "_bit"}, oSerial, v.exp[nn-1-k]);
        check({v.name, "_oe"}, oOutput_input, 1);
        check({v.name, "_early"}, oComplete, 0);
        tick();
      end
      check({v.name, "_complete"}, {oComplete, oTimeout, oSerial, oOutput_input, oBusy}, 5'b10101);
      tick();
      check({v.name, "_idle"}, {oComplete, oBusy, oSerial}, 3'b001);
    end else if (v.exp_to) begin
      iSerial = 1'b1;
      for (int k = 1; k <= 64; k++) begin
        tick();
        if (k < 64) check({v.name, "_early"}, oComplete, 0);
      end
      check({v.name, "_flags"}, {oComplete, oTimeout}, 2'b11);
      check({v.name, "_par_kept"}, oParallel, v.exp);
      tick();
      check({v.name, "_idle"}, {oComplete, oTimeout, oBusy}, 3'b000);
    end else begin
      for (int k = 0; k < v.pre; k++) begin
        iSerial = 1'b1;
        tick();
        check({v.name, "_wait"}, {oComplete, oOutput_input, oSerial}, 3'b001);
      end
      for (int k = nn - 1; k >= 0; k--) begin
        iSerial = v.par_in[k];
        tick();
        if (k > 0) check({v.name, "_early"}, oComplete, 0);
      end
      check({v.name, "_flags"}, {oComplete, oTimeout, oOutput_input}, 3'b100);
      check({v.name, "_par"}, oParallel, v.exp);
      iSerial = 1'b1;
      tick();
      check({v.name, "_idle"}, {oComplete, oBusy}, 2'b00);
    end
  endtask

  initial begin
    logic [7:0] a5;
    int         idx;
    logic       en;
    vec_t       post;

    a5 = 8'hA5;
    vecs[0] = '{"rx48",     MODE_RX, 6'd48, 48'h3F0000000101, 4, 48'h3F0000000101, 1'b0, 1'b1};
    vecs[1] = '{"rx_to",    MODE_RX, 6'd48, 48'h0,            0, 48'h3F0000000101, 1'b1, 1'b1};
    vecs[2] = '{"rx1",      MODE_RX, 6'd1,  48'h0,            2, 48'h0,            1'b0, 1'b1};
    vecs[3] = '{"rx8",      MODE_RX, 6'd8,  48'h5A,           0, 48'h5A,           1'b0, 1'b1};
    vecs[4] = '{"tx38",     MODE_TX, 6'd38, 48'd33,           0, 48'd33,           1'b0, 1'b1};
    vecs[5] = '{"tx4_hi",   MODE_TX, 6'd4,  48'hFFFFFFFFFFF5, 0, 48'h5,            1'b0, 1'b1};
    vecs[6] = '{"tx1",      MODE_TX, 6'd1,  48'h1,            0, 48'h1,            1'b0, 1'b1};
    vecs[7] = '{"tx48",     MODE_TX, 6'd48, 48'hC00000000003, 0, 48'hC00000000003, 1'b0, 1'b1};
    vecs[8] = '{"bad_n0",   MODE_TX, 6'd0,  48'hFF,           0, 48'h0,            1'b0, 1'b0};
    vecs[9] = '{"bad_n49",  MODE_RX, 6'd49, 48'h0,            0, 48'h0,            1'b0, 1'b0};

    iReset = 1'b1; iEnable = 1'b1; iMode = MODE_TX; iFramesize = '0;
    iLoad_send = 1'b0; iParallel = '0; iSerial = 1'b1;
    tick(); tick();
    iReset = 1'b0;
    tick();
    check("reset_ctrl", {oSerial, oOutput_input, oBusy, oComplete, oTimeout}, 5'b10000);
    check("reset_par", oParallel, 48'h0);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
      tick();
    end

    // Request while transmitting must not disturb the frame in flight.
    load(MODE_TX, 6'd8, 48'hA5);
    for (int k = 0; k < 8; k++) begin
      check("busy_req_bit", oSerial, a5[7-k]);
      if (k == 2) begin
        iMode = MODE_RX; iFramesize = 6'd4; iParallel = 48'h0; iLoad_send = 1'b1;
      end else begin
        iLoad_send = 1'b0;
      end
      tick();
    end
    check("busy_req_done", {oComplete, oTimeout}, 2'b10);
    tick();
    check("busy_req_idle", {oComplete, oBusy}, 2'b00);
    tick();

    // Five-cycle enable hold in the middle of a transmit, then a held completion.
    load(MODE_TX, 6'd8, 48'hA5);
    idx = 0;
    check("hold_bit", oSerial, a5[7]);
    for (int e = 1; e <= 13; e++) begin
      iEnable = !(e >= 4 && e <= 8);
      en = iEnable;
      tick();
      if (en) idx++;
      if (idx < 8) begin
        check("hold_bit", oSerial, a5[7-idx]);
        check("hold_early", oComplete, 0);
      end else begin
        check("hold_complete", oComplete, 1);
      end
    end
    iEnable = 1'b0;
    tick(); tick();
    check("hold_pending", {oComplete, oBusy}, 2'b11);
    iEnable = 1'b1;
    tick();
    check("hold_release", {oComplete, oBusy}, 2'b00);
    tick();

    // Asynchronous reset during RX_SHIFT.
    load(MODE_RX, 6'd8, 48'h0);
    iSerial = 1'b0; tick();
    iSerial = 1'b1; tick();
    iSerial = 1'b0; tick();
    iSerial = 1'b1; tick();
    check("rst_pre_busy", oBusy, 1);
    #2 iReset = 1'b1;
    #1;
    check("rst_ctrl", {oSerial, oOutput_input, oBusy, oComplete, oTimeout}, 5'b10000);
    check("rst_par", oParallel, 48'h0);
    tick();
    iReset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      iSerial = k[0];
      tick();
      check("rst_nocomplete", {oComplete, oBusy}, 2'b00);
    end
    iSerial = 1'b1;
    post = '{"post_rst_tx", MODE_TX, 6'd4, 48'h9, 0, 48'h9, 1'b0, 1'b1};
    run_vec(post);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
